// File: rtl/sprite_draw_scheduler_pkg.sv
`default_nettype none
// =============================================================================
// Module   : sprite_draw_scheduler_pkg
// Brief    : Shared state encoding and default widths for the sprite scheduler.
// Revision : 1.0
// =============================================================================
package sprite_draw_scheduler_pkg;

   localparam int c_def_x_width   = 10;
   localparam int c_def_y_width   = 10;
   localparam int c_def_sel_width = 2;

   typedef logic [2:0] state_t;

   localparam logic [2:0] c_idle       = 3'd0;
   localparam logic [2:0] c_load       = 3'd1;
   localparam logic [2:0] c_wait_start = 3'd2;
   localparam logic [2:0] c_wait_done  = 3'd3;
   localparam logic [2:0] c_ack        = 3'd4;

endpackage
`default_nettype wire

// File: rtl/sprite_draw_scheduler_if.sv
`default_nettype none
// =============================================================================
// Module   : sprite_draw_scheduler_if
// Brief    : Load/position bus between the scheduler and the stencil engine.
// Revision : 1.0
// =============================================================================
interface sprite_draw_scheduler_if
   import sprite_draw_scheduler_pkg::*;
#(
   parameter int X_WIDTH   = c_def_x_width,
   parameter int Y_WIDTH   = c_def_y_width,
   parameter int SEL_WIDTH = c_def_sel_width
);
   logic                 stc_we;
   logic [X_WIDTH-1:0]   stc_x;
   logic [Y_WIDTH-1:0]   stc_y;
   logic [SEL_WIDTH-1:0] stc_sel;
   logic                 stc_finish;

   modport master (output stc_we, stc_x, stc_y, stc_sel, input stc_finish);
   modport slave  (input stc_we, stc_x, stc_y, stc_sel, output stc_finish);
endinterface
`default_nettype wire

// File: rtl/sprite_draw_scheduler_rr_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : sprite_draw_scheduler_rr_arbiter
// Brief    : Combinational round-robin pick starting just above last_grant.
// Revision : 1.0
// =============================================================================
module sprite_draw_scheduler_rr_arbiter
   import sprite_draw_scheduler_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int SEL_WIDTH = c_def_sel_width
) (
   input  logic [NUM_REQ-1:0]   req,
   input  logic [SEL_WIDTH-1:0] last_grant,
   output logic [SEL_WIDTH-1:0] grant_idx,
   output logic                 grant_valid
);
   logic [NUM_REQ-1:0] w_upper;

   always_comb begin
      w_upper = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_upper[i] = req[i] && (SEL_WIDTH'(i) > last_grant);
      end
   end

   // Lowest set bit above last_grant wins; otherwise wrap to lowest set bit.
   always_comb begin
      grant_idx   = '0;
      grant_valid = |req;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[i]) grant_idx = SEL_WIDTH'(i);
      end
      if (|w_upper) begin
         for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_upper[i]) grant_idx = SEL_WIDTH'(i);
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/sprite_draw_scheduler.sv
`default_nettype none
// =============================================================================
// Module   : sprite_draw_scheduler
// Brief    : Round-robin sharing of one sprite stencil engine among requesters.
// Revision : 1.0
// =============================================================================
module sprite_draw_scheduler
   import sprite_draw_scheduler_pkg::*;
#(
   parameter int NUM_REQ       = 4,
   parameter int SEL_WIDTH     = c_def_sel_width,
   parameter int X_WIDTH       = c_def_x_width,
   parameter int Y_WIDTH       = c_def_y_width,
   parameter int START_TIMEOUT = 8
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ*X_WIDTH-1:0]   req_x,
   input  logic [NUM_REQ*Y_WIDTH-1:0]   req_y,
   output logic [NUM_REQ-1:0]           ack,
   input  logic                         draw_allow,
   output logic                         busy,
   output logic                         timeout_err,
   sprite_draw_scheduler_if.master      stc
);
   localparam int                     c_cnt_width = $clog2(START_TIMEOUT + 1);
   localparam logic [c_cnt_width-1:0] c_cnt_last  = c_cnt_width'(START_TIMEOUT - 1);

   state_t                 r_state;
   logic [SEL_WIDTH-1:0]   r_grant;
   logic [SEL_WIDTH-1:0]   r_last_grant;
   logic [c_cnt_width-1:0] r_cnt;
   logic                   r_we;
   logic [X_WIDTH-1:0]     r_x;
   logic [Y_WIDTH-1:0]     r_y;
   logic [NUM_REQ-1:0]     r_ack;
   logic                   r_busy;
   logic                   r_timeout;

   logic [X_WIDTH-1:0]     w_x [NUM_REQ];
   logic [Y_WIDTH-1:0]     w_y [NUM_REQ];
   logic [SEL_WIDTH-1:0]   w_grant_idx;
   logic                   w_grant_valid;
   logic                   w_launch;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign w_x[gi] = req_x[gi*X_WIDTH +: X_WIDTH];
         assign w_y[gi] = req_y[gi*Y_WIDTH +: Y_WIDTH];
      end
   endgenerate

   sprite_draw_scheduler_rr_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .SEL_WIDTH (SEL_WIDTH)
   ) u_arb (
      .req         (req),
      .last_grant  (r_last_grant),
      .grant_idx   (w_grant_idx),
      .grant_valid (w_grant_valid)
   );

   // The engine is not reset with us, so never launch while it reports busy.
   assign w_launch = draw_allow && stc.stc_finish && w_grant_valid;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= c_idle;
         r_grant      <= '0;
         r_last_grant <= SEL_WIDTH'(NUM_REQ - 1);
         r_cnt        <= '0;
         r_we         <= 1'b0;
         r_x          <= '0;
         r_y          <= '0;
         r_ack        <= '0;
         r_busy       <= 1'b0;
         r_timeout    <= 1'b0;
      end else begin
         r_ack     <= '0;
         r_timeout <= 1'b0;
         case (r_state)
            c_idle: begin
               if (w_launch) begin
                  r_state <= c_load;
                  r_we    <= 1'b1;
                  r_busy  <= 1'b1;
                  r_grant <= w_grant_idx;
                  r_x     <= w_x[w_grant_idx];
                  r_y     <= w_y[w_grant_idx];
               end
            end
            c_load: begin
               r_we    <= 1'b0;
               r_cnt   <= '0;
               r_state <= c_wait_start;
            end
            c_wait_start: begin
               if (!stc.stc_finish) begin
                  r_state <= c_wait_done;
               end else if (r_cnt == c_cnt_last) begin
                  // Engine never started: give up, requester retries after the others.
                  r_timeout    <= 1'b1;
                  r_last_grant <= r_grant;
                  r_busy       <= 1'b0;
                  r_state      <= c_idle;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            c_wait_done: begin
               if (stc.stc_finish) begin
                  r_ack   <= NUM_REQ'(1) << r_grant;
                  r_state <= c_ack;
               end
            end
            c_ack: begin
               r_last_grant <= r_grant;
               r_busy       <= 1'b0;
               r_state      <= c_idle;
            end
            default: begin
               r_we    <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= c_idle;
            end
         endcase
      end
   end

   assign stc.stc_we   = r_we;
   assign stc.stc_x    = r_x;
   assign stc.stc_y    = r_y;
   assign stc.stc_sel  = r_grant;
   assign ack          = r_ack;
   assign busy         = r_busy;
   assign timeout_err  = r_timeout;
endmodule
`default_nettype wire
